// File: rtl/rv_alu_pipe.sv
// RV32/64 R-type integer ALU with a one-entry valid/ready output register.
// Define RV_ALU_MUL_EN to add an iterative shift-add MUL (latency XLEN+1).
module rv_alu_pipe #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [6:0]      opcode,
   input  logic [2:0]      func3,
   input  logic [6:0]      func7,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out,
   output logic            illegal
);

   localparam int unsigned ShW = $clog2(XLEN);

   logic [ShW-1:0]  shamt;
   logic [XLEN-1:0] alu_res;
   logic            alu_illegal;
   logic            is_mul;
   logic            accept;
   logic            take;
   logic [XLEN-1:0] out_q;
   logic            illegal_q;
   logic            out_valid_q;

   assign shamt     = b[ShW-1:0];
   assign accept    = in_valid && in_ready;
   assign take      = out_valid_q && out_ready;
   assign out       = out_q;
   assign illegal   = illegal_q;
   assign out_valid = out_valid_q;

   always_comb begin
      alu_res     = '0;
      alu_illegal = 1'b1;
      is_mul      = 1'b0;
      if (opcode == 7'b0110011) begin
         if (func7 == 7'b0000000) begin
            alu_illegal = 1'b0;
            case (func3)
               3'b000:  alu_res = a + b;
               3'b001:  alu_res = a << shamt;
               3'b010:  alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
               3'b011:  alu_res = {{(XLEN-1){1'b0}}, a < b};
               3'b100:  alu_res = a ^ b;
               3'b101:  alu_res = a >> shamt;
               3'b110:  alu_res = a | b;
               default: alu_res = a & b;
            endcase
         end else if (func7 == 7'b0100000 && func3 == 3'b000) begin
            alu_illegal = 1'b0;
            alu_res     = a - b;
         end else if (func7 == 7'b0100000 && func3 == 3'b101) begin
            alu_illegal = 1'b0;
            alu_res     = $signed(a) >>> shamt;
`ifdef RV_ALU_MUL_EN
         end else if (func7 == 7'b0000001 && func3 == 3'b000) begin
            alu_illegal = 1'b0;
            is_mul      = 1'b1;
`endif
         end
      end
   end

`ifdef RV_ALU_MUL_EN
   typedef enum logic [0:0] {StIdle, StMulBusy} state_e;

   state_e          state_q;
   logic [XLEN-1:0] mul_acc_q;
   logic [XLEN-1:0] mul_a_q;
   logic [XLEN-1:0] mul_b_q;
   logic [ShW-1:0]  mul_cnt_q;
   logic [XLEN-1:0] mul_sum;

   assign mul_sum  = mul_acc_q + (mul_b_q[0] ? mul_a_q : '0);
   assign in_ready = (state_q == StIdle) && (!out_valid_q || out_ready) && !rst;
`else
   assign in_ready = (!out_valid_q || out_ready) && !rst;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_q       <= '0;
         illegal_q   <= 1'b0;
`ifdef RV_ALU_MUL_EN
         state_q     <= StIdle;
         mul_acc_q   <= '0;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
         mul_cnt_q   <= '0;
`endif
      end else begin
         if (take) begin
            out_valid_q <= 1'b0;
         end
         if (accept && !is_mul) begin
            out_q       <= alu_res;
            illegal_q   <= alu_illegal;
            out_valid_q <= 1'b1;
         end
`ifdef RV_ALU_MUL_EN
         // One partial product per edge; the count runs XLEN-1 down to 0.
         if (accept && is_mul) begin
            state_q   <= StMulBusy;
            mul_acc_q <= '0;
            mul_a_q   <= a;
            mul_b_q   <= b;
            mul_cnt_q <= ShW'(XLEN - 1);
         end
         if (state_q == StMulBusy) begin
            mul_acc_q <= mul_sum;
            mul_a_q   <= mul_a_q << 1;
            mul_b_q   <= mul_b_q >> 1;
            mul_cnt_q <= mul_cnt_q - 1'b1;
            if (mul_cnt_q == '0) begin
               out_q       <= mul_sum;
               illegal_q   <= 1'b0;
               out_valid_q <= 1'b1;
               state_q     <= StIdle;
            end
         end
`endif
      end
   end

endmodule

// File: tb/tb_rv_alu_pipe.sv
// Scoreboard bench for rv_alu_pipe: directed vectors, random ops vs. an arithmetic model,
// backpressure and reset-abort; honours RV_ALU_MUL_EN when defined.
module tb_rv_alu_pipe;

   localparam int unsigned XLEN = 32;

   typedef struct {
      logic [XLEN-1:0] o;
      logic            ill;
      int              lat;
   } exp_t;

   typedef struct {
      logic [XLEN-1:0] o;
      logic            ill;
      int              due;
   } sb_t;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [6:0]      opcode = '0;
   logic [2:0]      func3 = '0;
   logic [6:0]      func7 = '0;
   logic [XLEN-1:0] a = '0;
   logic [XLEN-1:0] b = '0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [XLEN-1:0] out;
   logic            illegal;

   int  nchk = 0;
   int  nerr = 0;
   int  cyc = 0;
   int  rdy_mode = 1;
   sb_t sb[$];

   rv_alu_pipe #(.XLEN(XLEN)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .opcode    (opcode),
      .func3     (func3),
      .func7     (func7),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .illegal   (illegal)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       out_ready = ($urandom_range(0, 3) != 0);
         1:       out_ready = 1'b1;
         default: out_ready = 1'b0;
      endcase
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: plain integer arithmetic on the instruction semantics.
   function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3,
                                  input logic [6:0] f7, input logic [XLEN-1:0] av,
                                  input logic [XLEN-1:0] bv);
      exp_t            r;
      longint unsigned ua, ub, p2;
      logic [XLEN-1:0] na;
      int              sh;
      ua    = longint'(av);
      ub    = longint'(bv);
      sh    = int'(bv % XLEN);
      p2    = 64'd1 << sh;
      na    = ~av;
      r.o   = '0;
      r.ill = 1'b1;
      r.lat = 1;
      if (op == 7'h33 && f7 == 7'h00) begin
         r.ill = 1'b0;
         case (f3)
            3'd0:    r.o = XLEN'(ua + ub);
            3'd1:    r.o = XLEN'(ua * p2);
            3'd2:    r.o = ($signed(av) < $signed(bv)) ? 1 : 0;
            3'd3:    r.o = (ua < ub) ? 1 : 0;
            3'd4:    r.o = av ^ bv;
            3'd5:    r.o = XLEN'(ua / p2);
            3'd6:    r.o = av | bv;
            default: r.o = av & bv;
         endcase
      end else if (op == 7'h33 && f7 == 7'h20 && f3 == 3'd0) begin
         r.ill = 1'b0;
         r.o   = XLEN'(ua + (64'd1 << XLEN) - ub);
      end else if (op == 7'h33 && f7 == 7'h20 && f3 == 3'd5) begin
         r.ill = 1'b0;
         r.o   = av[XLEN-1] ? ~XLEN'(longint'(na) / p2) : XLEN'(ua / p2);
      end
`ifdef RV_ALU_MUL_EN
      else if (op == 7'h33 && f7 == 7'h01 && f3 == 3'd0) begin
         r.ill = 1'b0;
         r.lat = XLEN + 1;
         r.o   = XLEN'(ua * ub);
      end
`endif
      return r;
   endfunction

   // Holds the request until accepted; entered and left at posedge+1.
   task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [XLEN-1:0] av, input logic [XLEN-1:0] bv,
                        input logic [XLEN-1:0] eo, input logic ei, input int lat,
                        input bit push);
      int n = 0;
      opcode   = op;
      func3    = f3;
      func7    = f7;
      a        = av;
      b        = bv;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("accept_timeout", 64'd0, 64'd1);
      else if (push) sb.push_back('{eo, ei, cyc + lat});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      opcode   = 7'($urandom);
      a        = $urandom;
      b        = $urandom;
   endtask

   task automatic issue_model(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [XLEN-1:0] av, input logic [XLEN-1:0] bv);
      exp_t e;
      e = model(op, f3, f7, av, bv);
      issue(op, f3, f7, av, bv, e.o, e.ill, e.lat, 1'b1);
   endtask

   // Monitor: latency on a fresh result, stability while held, pop on take.
   logic            prev_valid = 1'b0;
   logic            prev_take = 1'b0;
   logic [XLEN-1:0] held_out = '0;
   logic            held_ill = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         prev_valid = 1'b0;
         prev_take  = 1'b0;
      end else begin
         if (out_valid) begin
            if (!prev_valid || prev_take) begin
               if (sb.size() == 0) chk("spurious_result", 64'd1, 64'd0);
               else chk("latency", 64'(cyc), 64'(sb[0].due));
            end else begin
               chk("held_out", 64'(out), 64'(held_out));
               chk("held_illegal", 64'(illegal), 64'(held_ill));
            end
            if (out_ready && sb.size() != 0) begin
               chk("out", 64'(out), 64'(sb[0].o));
               chk("illegal", 64'(illegal), 64'(sb[0].ill));
               void'(sb.pop_front());
            end
            held_out = out;
            held_ill = illegal;
         end
         prev_valid = out_valid;
         prev_take  = out_valid && out_ready;
      end
   end

   initial begin
      logic [6:0]      op, f7;
      logic [XLEN-1:0] av, bv;
      logic [XLEN-1:0] corner [5];
      int              seen, n;
      corner[0] = '0;
      corner[1] = 1;
      corner[2] = '1;
      corner[3] = 32'h8000_0000;
      corner[4] = 32'h7FFF_FFFF;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out", 64'(out), 64'd0);
      chk("rst_illegal", 64'(illegal), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("in_ready_after_rst", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;

      issue(7'h33, 3'd0, 7'h00, 32'hFFFF_FFFF, 32'h2, 32'h1, 1'b0, 1, 1'b1);
      issue(7'h33, 3'd0, 7'h20, 32'h5, 32'h7, 32'hFFFF_FFFE, 1'b0, 1, 1'b1);
      issue(7'h33, 3'd5, 7'h20, 32'h8000_0000, 32'h24, 32'hF800_0000, 1'b0, 1, 1'b1);
      issue(7'h33, 3'd2, 7'h00, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 1, 1'b1);
      issue(7'h33, 3'd3, 7'h00, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1, 1'b1);
      issue(7'h13, 3'd0, 7'h00, 32'h1234, 32'h1, 32'h0, 1'b1, 1, 1'b1);
      issue(7'h33, 3'd1, 7'h20, 32'h1234, 32'h1, 32'h0, 1'b1, 1, 1'b1);
`ifdef RV_ALU_MUL_EN
      issue(7'h33, 3'd0, 7'h01, 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b0, 33, 1'b1);
      issue(7'h33, 3'd0, 7'h01, 32'h7, 32'h6, 32'h2A, 1'b0, 33, 1'b1);
`else
      issue(7'h33, 3'd0, 7'h01, 32'h7, 32'h6, 32'h0, 1'b1, 1, 1'b1);
`endif

      // Backpressure: first result must sit until out_ready returns.
      rdy_mode = 2;
      @(posedge clk);
      #2;
      issue(7'h33, 3'd0, 7'h00, 32'h1, 32'h2, 32'h3, 1'b0, 1, 1'b1);
      fork
         issue(7'h33, 3'd4, 7'h00, 32'hF0F0, 32'h0FF0, 32'hFF00, 1'b0, 1, 1'b1);
         begin
            repeat (3) begin
               @(negedge clk);
               chk("bp_in_ready", 64'(in_ready), 64'd0);
               chk("bp_held", 64'(out), 64'd3);
            end
            rdy_mode = 1;
         end
      join

      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 19) == 0) rdy_mode = ($urandom_range(0, 3) == 0) ? 1 : 0;
         op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : 7'h33;
         n  = $urandom_range(0, 9);
         f7 = (n < 6) ? 7'h00 : (n < 8) ? 7'h20 : (n == 8) ? 7'h01 : 7'($urandom);
         av = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
         bv = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
         issue_model(op, 3'($urandom), f7, av, bv);
      end

      rdy_mode = 1;
      n = 0;
      while (sb.size() != 0 && n < 2000) begin
         @(posedge clk);
         n++;
      end
      chk("drain_empty", 64'(sb.size()), 64'd0);

`ifdef RV_ALU_MUL_EN
      // Reset ten edges into a multiply: nothing may emerge.
      @(posedge clk);
      #1;
      issue(7'h33, 3'd0, 7'h01, 32'h7, 32'h6, 32'h2A, 1'b0, 33, 1'b0);
      repeat (9) @(posedge clk);
      #1 rst = 1'b1;
      sb.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("abort_in_ready", 64'(in_ready), 64'd1);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("abort_no_result", 64'(seen), 64'd0);
`endif

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/rv_alu_pipe.md
RV_ALU_PIPE -- requirements
Module: rv_alu_pipe

Interface
REQ-001 The block SHALL have one parameter: XLEN, default 32, operand/result width; legal values are powers of two from 8 to 64.
REQ-002 The block SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 The block SHALL have port in_valid, input, 1, request presented.
REQ-005 The block SHALL have port in_ready, output, 1, block can accept a request this cycle.
REQ-006 The block SHALL have ports opcode input 7, func3 input 3 and func7 input 7, carrying the RV R-type instruction fields.
REQ-007 The block SHALL have ports a input XLEN and b input XLEN, carrying rs1 and rs2 operand values.
REQ-008 The block SHALL have port out_valid, output, 1, result held in output register.
REQ-009 The block SHALL have port out_ready, input, 1, consumer takes result this cycle.
REQ-010 The block SHALL have port out, output, XLEN, result value.
REQ-011 The block SHALL have port illegal, output, 1, flags the current result as coming from an unsupported encoding.

Function
REQ-012 A request SHALL be accepted on a rising edge where in_valid && in_ready; the block SHALL sample all inputs only on that edge.
REQ-013 The output SHALL be taken on a rising edge where out_valid && out_ready.
REQ-014 in_ready SHALL be combinational: state==IDLE && (!out_valid || out_ready) && !rst.
REQ-015 The FSM SHALL have the states IDLE, MUL_BUSY and the output register flag out_valid; no other states.
REQ-016 Single-cycle ops SHALL complete with latency 1: out, illegal and out_valid=1 are set on the accept edge.
REQ-017 The op table SHALL apply only when opcode=0110011. func7=0000000: func3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND. func7=0100000: func3 000 SUB, 101 SRA.
REQ-018 ADD and SUB SHALL wrap modulo 2^XLEN; no carry or overflow output.
REQ-019 The shift amount SHALL be b[log2(XLEN)-1:0]; SRA SHALL replicate a[XLEN-1].
REQ-020 SLT (signed) and SLTU (unsigned) SHALL yield 1 or 0, zero-extended to XLEN.
REQ-021 Any other encoding SHALL produce out=0 and illegal=1 with latency 1; a legal op SHALL produce illegal=0.
REQ-022 out and illegal SHALL stay stable while out_valid && !out_ready.
REQ-023 A same-edge take and new accept SHALL be supported: the new result replaces the old with out_valid held at 1, giving one result per cycle.
REQ-024 The block SHALL NOT drop, duplicate or reorder results.

Reset
REQ-025 While rst=1 on a rising edge, the block SHALL set state=IDLE, out_valid=0, out=0, illegal=0 and clear the multiplier registers.
REQ-026 Reset asserted mid-multiply SHALL abort the operation with no result emitted; a pending unconsumed result SHALL be discarded.
REQ-027 On the first edge after rst falls, the block SHALL be able to accept a request.

Configuration
REQ-028 With macro RV_ALU_MUL_EN defined, the encoding opcode=0110011, func7=0000001, func3=000 (MUL) SHALL be legal and return the low XLEN bits of a*b.
REQ-029 MUL SHALL use an iterative shift-add: the accept edge enters MUL_BUSY, XLEN further edges iterate, and the final iteration edge writes out, sets out_valid=1 and returns to IDLE, for a latency of XLEN+1 edges.
REQ-030 In MUL_BUSY, in_ready SHALL be 0.
REQ-031 Without RV_ALU_MUL_EN, the MUL encoding SHALL be illegal per REQ-021, and no multiplier logic or MUL_BUSY state SHALL be synthesised.

Verification
REQ-032 Add wrap: XLEN=32, ADD a=FFFFFFFF b=00000002 -> next edge out=00000001, out_valid=1, illegal=0.
REQ-033 Signed ops: SUB a=5 b=7 -> FFFFFFFE; SRA a=80000000 b=0000_0024 (shamt 4) -> F8000000; SLT a=FFFFFFFF b=1 -> 1; SLTU with the same operands -> 0.
REQ-034 Backpressure: out_ready=0 with two back-to-back requests -> first result held stable, in_ready=0, second accepted on the edge out_ready rises, no loss.
REQ-035 Illegal: opcode=0010011 or func7=0100000 func3=001 -> out=0, illegal=1 after 1 edge.
REQ-036 MUL_EN: MUL a=00010000 b=00010000 -> out=00000000 after 33 edges; a=7 b=6 -> 0000002A; rst pulsed at cycle 10 of a multiply -> out_valid never rises, in_ready=1 on the first edge after reset.
